mips_mc_control: RTL and testbench

- Multi-cycle control unit for the MIPS core; next-generation successor to the single-cycle control path.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared-ALU, single-memory datapath.
- Adds a memory ready/request handshake, a parametrised wait-state watchdog, sticky fault reporting and a retired-instruction counter.

---
 rtl/mips_mc_control_if.sv | 40 ++++
 rtl/mips_mc_control.sv | 201 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS control unit.
// master: the control unit (consumes op/zero/mem_ready, drives all control strobes,
//         fault status, state and the retired-instruction count).
// slave:  the datapath/memory side.
interface mips_mc_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             RegWr;
  logic             RegDst;
  logic             MemtoReg;
  logic             ExtOp;
  logic             AluSrcA;
  logic [1:0]       AluSrcB;
  logic [1:0]       ALUop;
  logic             fault;
  logic [1:0]       fault_code;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWr, RegDst, MemtoReg,
           ExtOp, AluSrcA, AluSrcB, ALUop, fault, fault_code, state, retired
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWr, RegDst, MemtoReg,
           ExtOp, AluSrcA, AluSrcB, ALUop, fault, fault_code, state, retired
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a shared-ALU,
// single-memory datapath, with a memory request/ready handshake, a wait-state watchdog,
// a sticky fault state and a retired-instruction counter.
// Ports: clk (rising edge), reset (async, active-high), bus (master side of
// mips_mc_control_if: op/zero/mem_ready in; control strobes, fault, state, retired out).
module mips_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  mips_mc_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,  StDecode = 4'd1, StMemAddr = 4'd2, StMemRd = 4'd3,
    StWbMem   = 4'd4,  StMemWr  = 4'd5, StExecR   = 4'd6, StWbR   = 4'd7,
    StExecI   = 4'd8,  StWbI    = 4'd9, StBranch  = 4'd10, StJump = 4'd11,
    StFault   = 4'd15
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [TO_W-1:0] WdLimit = TO_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_op_c;
  logic       reg_wr_c, reg_dst_c, mem_to_reg_c, ext_op_c, alu_src_a_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      code_q    <= 2'b00;
      wd_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wd_q    <= wd_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    wd_d         = '0;
    retire       = 1'b0;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord_c       = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'b00;
    reg_wr_c     = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    ext_op_c     = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;

    case (state_q)
      StFetch: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        alu_src_b_c = 2'b11;
        ext_op_c    = 1'b1;
        case (bus.op)
          OpRtype:       state_d = StExecR;
          OpLw, OpSw:    state_d = StMemAddr;
          OpAddi, OpOri: state_d = StExecI;
          OpBeq:         state_d = StBranch;
          OpJ:           state_d = StJump;
          default: begin
            state_d = StFault;
            code_d  = 2'b01;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        ext_op_c    = 1'b1;
        state_d     = (bus.op == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) state_d = StWbMem;
      end
      StWbMem: begin
        reg_wr_c     = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = StFetch;
        retire       = 1'b1;
      end
      StMemWr: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (bus.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = StWbR;
      end
      StWbR: begin
        reg_wr_c  = 1'b1;
        reg_dst_c = 1'b1;
        state_d   = StFetch;
        retire    = 1'b1;
      end
      StExecI: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (bus.op == OpOri) begin
          alu_op_c = 2'b11;
        end else begin
          ext_op_c = 1'b1;
        end
        state_d = StWbI;
      end
      StWbI: begin
        reg_wr_c = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StBranch: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 2'b01;
        pc_write_c  = bus.zero;
        state_d     = StFetch;
        retire      = 1'b1;
      end
      StJump: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        state_d    = StFetch;
        retire     = 1'b1;
      end
      StFault: ;
      default: state_d = StFault;
    endcase

    // Watchdog only counts while a request stalls; leaving or completing a request clears it,
    // so every request state is entered with a zero count.
    if (mem_req_c && !bus.mem_ready) begin
      if (MEM_TIMEOUT != 0 && wd_q == WdLimit) begin
        state_d = StFault;
        code_d  = 2'b10;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  assign bus.mem_req    = mem_req_c    & ~reset;
  assign bus.mem_we     = mem_we_c     & ~reset;
  assign bus.IorD       = iord_c       & ~reset;
  assign bus.IRWrite    = ir_write_c   & ~reset;
  assign bus.PCWrite    = pc_write_c   & ~reset;
  assign bus.PCSrc      = reset ? 2'b00 : pc_src_c;
  assign bus.RegWr      = reg_wr_c     & ~reset;
  assign bus.RegDst     = reg_dst_c    & ~reset;
  assign bus.MemtoReg   = mem_to_reg_c & ~reset;
  assign bus.ExtOp      = ext_op_c     & ~reset;
  assign bus.AluSrcA    = alu_src_a_c  & ~reset;
  assign bus.AluSrcB    = reset ? 2'b00 : alu_src_b_c;
  assign bus.ALUop      = reset ? 2'b00 : alu_op_c;
  assign bus.fault      = (state_q == StFault);
  assign bus.fault_code = code_q;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control (MEM_TIMEOUT=4, CNT_W=3). The driver walks each instruction
// through the expected state sequence and queues one expected record per cycle; the
// monitor pops one record per cycle on the falling edge and compares it with the DUT.
module tb_mips_mc_control;

  localparam int Timeout = 4;

  localparam logic [3:0] SFetch = 4'd0,  SDecode = 4'd1, SMemAddr = 4'd2, SMemRd = 4'd3;
  localparam logic [3:0] SWbMem = 4'd4,  SMemWr  = 4'd5, SExecR   = 4'd6, SWbR   = 4'd7;
  localparam logic [3:0] SExecI = 4'd8,  SWbI    = 4'd9, SBranch  = 4'd10, SJump = 4'd11;
  localparam logic [3:0] SFault = 4'd15;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpAddi = 6'b001000, OpOri = 6'b001101, OpBeq = 6'b000100;
  localparam logic [5:0] OpJ = 6'b000010;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        flt;
    logic [1:0]  code;
    logic [2:0]  ret;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mc_control_if #(.CNT_W(3)) bus ();

  mips_mc_control #(
    .MEM_TIMEOUT(Timeout),
    .TO_W       (3),
    .CNT_W      (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  rec_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] exp_ret = '0;
  logic [1:0] exp_code = '0;

  // Control table straight from the state descriptions; packing order
  // {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc, RegWr, RegDst, MemtoReg, ExtOp,
  //  AluSrcA, AluSrcB, ALUop}.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [5:0] o,
                                            input logic z, input logic rdy);
    logic req = 0, we = 0, iord = 0, irw = 0, pcw = 0, rw = 0, rd = 0, m2r = 0, ext = 0;
    logic sa = 0;
    logic [1:0] psrc = 0, sb = 0, aop = 0;
    case (st)
      SFetch:   begin req = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      SDecode:  begin sb = 2'b11; ext = 1; end
      SMemAddr: begin sa = 1; sb = 2'b10; ext = 1; end
      SMemRd:   begin req = 1; iord = 1; end
      SWbMem:   begin rw = 1; m2r = 1; end
      SMemWr:   begin req = 1; we = 1; iord = 1; end
      SExecR:   begin sa = 1; aop = 2'b10; end
      SWbR:     begin rw = 1; rd = 1; end
      SExecI:   begin sa = 1; sb = 2'b10; ext = (o == OpAddi); aop = (o == OpOri) ? 2'b11 : 2'b00; end
      SWbI:     rw = 1;
      SBranch:  begin sa = 1; aop = 2'b01; psrc = 2'b01; pcw = z; end
      SJump:    begin psrc = 2'b10; pcw = 1; end
      default:  ;
    endcase
    return {req, we, iord, irw, pcw, psrc, rw, rd, m2r, ext, sa, sb, aop};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs, queue the expectation, advance past the next rising edge.
  task automatic step(input logic [3:0] st, input logic rdy, input logic rst_v);
    rec_t r;
    reset         = rst_v;
    bus.mem_ready = rdy;
    if (rst_v) begin
      exp_ret  = '0;
      exp_code = '0;
    end
    r.st   = st;
    r.ctrl = rst_v ? 16'h0 : exp_ctrl(st, bus.op, bus.zero, rdy);
    r.flt  = (st == SFault);
    r.code = exp_code;
    r.ret  = exp_ret;
    exp_q.push_back(r);
    if (!rst_v && ((st == SWbMem) || (st == SWbR) || (st == SWbI) || (st == SBranch) ||
                   (st == SJump) || (st == SMemWr && rdy))) exp_ret = exp_ret + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic fault_hold();
    int n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) step(SFault, rbit(), 1'b0);
    step(SFetch, rbit(), 1'b1);
  endtask

  // Request phase with `waits` stalled cycles; returns 1 if the watchdog fires.
  task automatic mem_phase(input logic [3:0] st, input int waits, output logic timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < waits && i < Timeout; i++) step(st, 1'b0, 1'b0);
    if (waits >= Timeout) begin
      exp_code = 2'b10;
      fault_hold();
      timed_out = 1'b1;
    end else begin
      step(st, 1'b1, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input logic z);
    logic to;
    bus.op   = o;
    bus.zero = z;
    mem_phase(SFetch, fw, to);
    if (to) return;
    step(SDecode, rbit(), 1'b0);
    case (o)
      OpR:           begin step(SExecR, rbit(), 1'b0); step(SWbR, rbit(), 1'b0); end
      OpLw: begin
        step(SMemAddr, rbit(), 1'b0);
        mem_phase(SMemRd, mw, to);
        if (!to) step(SWbMem, rbit(), 1'b0);
      end
      OpSw: begin
        step(SMemAddr, rbit(), 1'b0);
        mem_phase(SMemWr, mw, to);
      end
      OpAddi, OpOri: begin step(SExecI, rbit(), 1'b0); step(SWbI, rbit(), 1'b0); end
      OpBeq:         step(SBranch, rbit(), 1'b0);
      OpJ:           step(SJump, rbit(), 1'b0);
      default: begin
        exp_code = 2'b01;
        fault_hold();
      end
    endcase
  endtask

  // sw interrupted by reset while stalled in MEM_WR.
  task automatic run_sw_abort(input int k);
    bus.op = OpSw;
    step(SFetch, 1'b1, 1'b0);
    step(SDecode, rbit(), 1'b0);
    step(SMemAddr, rbit(), 1'b0);
    for (int i = 0; i < k; i++) step(SMemWr, 1'b0, 1'b0);
    step(SFetch, 1'b0, 1'b1);
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 11) == 0) ? Timeout : int'($urandom_range(0, Timeout - 1));
  endfunction

  // Monitor
  initial begin
    rec_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.st   = bus.state;
        a.ctrl = {bus.mem_req, bus.mem_we, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSrc,
                  bus.RegWr, bus.RegDst, bus.MemtoReg, bus.ExtOp, bus.AluSrcA, bus.AluSrcB,
                  bus.ALUop};
        a.flt  = bus.fault;
        a.code = bus.fault_code;
        a.ret  = bus.retired;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_vec t=%0t got st=%0d ctrl=%h flt=%b code=%b ret=%0d exp st=%0d ctrl=%h flt=%b code=%b ret=%0d",
                   $time, a.st, a.ctrl, a.flt, a.code, a.ret, e.st, e.ctrl, e.flt, e.code, e.ret);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [5:0] legal[7] = '{OpR, OpLw, OpSw, OpAddi, OpOri, OpBeq, OpJ};
    logic [5:0] illegal[3] = '{6'b111111, 6'b000001, 6'b110000};
    bus.op = OpR;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(SFetch, 1'b0, 1'b1);
    run_instr(OpR, 0, 0, 1'b0);
    run_instr(OpLw, 0, 3, 1'b0);
    run_instr(OpBeq, 0, 0, 1'b1);
    run_instr(OpBeq, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OpAddi, Timeout, 0, 1'b0);
    run_instr(OpAddi, Timeout - 1, 0, 1'b0);
    run_instr(OpSw, 1, Timeout, 1'b0);
    step(SFetch, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) run_instr(OpJ, 0, 0, 1'b0);
    run_sw_abort(2);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        run_sw_abort($urandom_range(0, Timeout - 1));
      end else if ($urandom_range(0, 19) == 0) begin
        run_instr(illegal[$urandom_range(0, 2)], pick_wait(), 0, rbit());
      end else begin
        run_instr(legal[$urandom_range(0, 6)], pick_wait(), pick_wait(), rbit());
      end
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached t=%0t required completion earlier", $time);
    $fatal(1, "bench time limit");
  end

endmodule
